// File: rtl/hd_top.sv
// hd_top: two-stage pipelined Hamming single-error-correcting decoder.
// Stage 1 registers the codeword and its syndrome; stage 2 corrects,
// extracts the data bits and registers the outputs.
// Optional feature macro: HD_ERR_CNT_EN enables the saturating
// corrected/uncorrectable word counters (ccnt, ucnt) and cnt_clr.
module hd_top #(
  parameter int k = 7,
  parameter int m = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [k+m-1:0] cin,
  input  logic           cvld,
  input  logic           cnt_clr,
  output logic [k-1:0]   dout,
  output logic           dvld,
  output logic [m-1:0]   syn,
  output logic           cerr,
  output logic           uerr,
  output logic [15:0]    ccnt,
  output logic [15:0]    ucnt
);

  localparam int n = k + m;

  logic [m-1:0] syn_c;
  logic [n-1:0] cw1;
  logic [m-1:0] syn1;
  logic         vld1;
  logic [k-1:0] data_c;
  logic         cerr_c;
  logic         uerr_c;

  // Syndrome: XOR of the position numbers of every set codeword bit.
  always_comb begin
    syn_c = '0;
    for (int unsigned p = 1; p <= n; p++) begin
      if (cin[p-1]) syn_c = syn_c ^ p[m-1:0];
    end
  end

  // Stage 1: capture codeword, syndrome and valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld1 <= 1'b0;
      cw1  <= '0;
      syn1 <= '0;
    end else begin
      vld1 <= cvld;
      if (cvld) begin
        cw1  <= cin;
        syn1 <= syn_c;
      end
    end
  end

  // Correction and data extraction from the stage-1 word.
  always_comb begin
    logic [n-1:0] fixed;
    int unsigned  idx;
    fixed  = cw1;
    cerr_c = 1'b0;
    uerr_c = 1'b0;
    data_c = '0;
    idx    = 0;
    if (syn1 != '0) begin
      if (int'(syn1) <= n) begin
        fixed[syn1 - 1'b1] = ~cw1[syn1 - 1'b1];
        cerr_c = 1'b1;
      end else begin
        uerr_c = 1'b1;
      end
    end
    // Data bits occupy the non-power-of-two positions in ascending order.
    for (int unsigned p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (idx < k) data_c[idx] = fixed[p-1];
        idx++;
      end
    end
  end

  // Stage 2: register outputs; status holds while no word is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvld <= 1'b0;
      dout <= '0;
      syn  <= '0;
      cerr <= 1'b0;
      uerr <= 1'b0;
    end else begin
      dvld <= vld1;
      if (vld1) begin
        dout <= data_c;
        syn  <= syn1;
        cerr <= cerr_c;
        uerr <= uerr_c;
      end
    end
  end

`ifdef HD_ERR_CNT_EN
  // Saturating error counters; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccnt <= '0;
      ucnt <= '0;
    end else if (cnt_clr) begin
      ccnt <= '0;
      ucnt <= '0;
    end else begin
      if (dvld && cerr && (ccnt != '1)) ccnt <= ccnt + 16'd1;
      if (dvld && uerr && (ucnt != '1)) ucnt <= ucnt + 16'd1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign ccnt = '0;
  assign ucnt = '0;
`endif

endmodule

// File: tb/tb_hd_top.sv
// tb_hd_top: randomized scoreboard bench for hd_top (k=7, m=4).
module tb_hd_top;

  localparam int K = 7;
  localparam int M = 4;
  localparam int N = K + M;

`ifdef HD_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
  localparam int STREAM = 70000;
`else
  localparam bit CNT_ON = 1'b0;
  localparam int STREAM = 2000;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   cin;
  logic           cvld;
  logic           cnt_clr;
  logic [K-1:0]   dout;
  logic           dvld;
  logic [M-1:0]   syn;
  logic           cerr;
  logic           uerr;
  logic [15:0]    ccnt;
  logic [15:0]    ucnt;

  hd_top #(.k(K), .m(M)) dut (
    .clk(clk), .rst(rst), .cin(cin), .cvld(cvld), .cnt_clr(cnt_clr),
    .dout(dout), .dvld(dvld), .syn(syn), .cerr(cerr), .uerr(uerr),
    .ccnt(ccnt), .ucnt(ucnt)
  );

  typedef struct {
    logic [K-1:0] d;
    logic [M-1:0] s;
    logic         c;
    logic         u;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   m_ccnt = 0;
  int   m_ucnt = 0;
  int   dpos [K] = '{3, 5, 6, 7, 9, 10, 11};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] encode(input logic [K-1:0] d);
    logic [N-1:0] w;
    logic         par;
    w = '0;
    for (int i = 0; i < K; i++) w[dpos[i]-1] = d[i];
    for (int i = 0; i < M; i++) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++)
        if (((p >> i) & 1) == 1 && p != (1 << i)) par ^= w[p-1];
      w[(1 << i) - 1] = par;
    end
    return w;
  endfunction

  function automatic logic [K-1:0] extract(input logic [N-1:0] w);
    logic [K-1:0] d;
    for (int i = 0; i < K; i++) d[i] = w[dpos[i]-1];
    return d;
  endfunction

  task automatic send(input logic [N-1:0] w, input logic [K-1:0] d,
                      input logic [M-1:0] s, input logic c, input logic u);
    exp_t e;
    e.d = d; e.s = s; e.c = c; e.u = u;
    e.due = edge_cnt + 2;
    cin  = w;
    cvld = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    cvld = 1'b0;
  endtask

  task automatic idle(input int cycles);
    cvld = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      cin = N'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // nerr bit flips at distinct positions; expectations follow the decoding rules.
  task automatic send_rand(input int nerr);
    logic [K-1:0] d;
    logic [N-1:0] w, b;
    int p1, p2, s;
    d = K'($urandom);
    w = encode(d);
    if (nerr == 0) begin
      send(w, d, '0, 1'b0, 1'b0);
    end else if (nerr == 1) begin
      p1 = $urandom_range(N, 1);
      w[p1-1] = ~w[p1-1];
      send(w, d, M'(p1), 1'b1, 1'b0);
    end else begin
      p1 = $urandom_range(N, 1);
      do p2 = $urandom_range(N, 1); while (p2 == p1);
      w[p1-1] = ~w[p1-1];
      w[p2-1] = ~w[p2-1];
      s = p1 ^ p2;
      if (s <= N) begin
        b = w;
        b[s-1] = ~b[s-1];
        send(w, extract(b), M'(s), 1'b1, 1'b0);
      end else begin
        send(w, extract(w), M'(s), 1'b0, 1'b1);
      end
    end
  endtask

  // Monitor: compares presented outputs and counters against the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      m_ccnt = 0;
      m_ucnt = 0;
      last = '{d: '0, s: '0, c: 1'b0, u: 1'b0, due: 0};
    end else begin
      chk("ccnt", 32'(ccnt), 32'(m_ccnt));
      chk("ucnt", 32'(ucnt), 32'(m_ucnt));
      if (dvld) begin
        if (sb.size() == 0) begin
          chk("unexpected_dvld", 32'(dvld), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("latency", 32'(edge_cnt), 32'(e.due));
          chk("dout", 32'(dout), 32'(e.d));
          chk("syn", 32'(syn), 32'(e.s));
          chk("cerr_uerr", {30'd0, cerr, uerr}, {30'd0, e.c, e.u});
          last = e;
        end
      end else begin
        chk("hold", {18'd0, dout, syn, cerr, uerr}, {18'd0, last.d, last.s, last.c, last.u});
        if (sb.size() > 0 && sb[0].due < edge_cnt) begin
          chk("missing_dvld", 32'(dvld), 32'(1));
          void'(sb.pop_front());
        end
      end
      if (CNT_ON) begin
        if (cnt_clr) begin
          m_ccnt = 0;
          m_ucnt = 0;
        end else begin
          if (dvld && cerr && m_ccnt < 16'hFFFF) m_ccnt++;
          if (dvld && uerr && m_ucnt < 16'hFFFF) m_ucnt++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cvld = 1'b0; cnt_clr = 1'b0; cin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {dvld, cerr, uerr, dout, syn}, '0);
    chk("reset_counters", {ccnt, ucnt}, '0);
    rst = 1'b1;
    idle(2);

    // Known vectors: clean, data-bit error, double parity error, parity-bit error.
    send(11'h484, 7'h41, 4'd0, 1'b0, 1'b0);
    idle(2);
    send(11'h494, 7'h41, 4'd5, 1'b1, 1'b0);
    idle(1);
    send(11'h40C, 7'h41, 4'd12, 1'b0, 1'b1);
    send(11'h485, 7'h41, 4'd1, 1'b1, 1'b0);
    idle(3);
    chk("ccnt_directed", 32'(ccnt), CNT_ON ? 32'd2 : 32'd0);
    chk("ucnt_directed", 32'(ucnt), CNT_ON ? 32'd1 : 32'd0);

    // Random words with random gaps and occasional counter clears.
    for (int i = 0; i < 400; i++) begin
      cnt_clr = ($urandom_range(19, 0) == 0);
      if ($urandom_range(9, 0) < 7) send_rand($urandom_range(2, 0));
      else idle($urandom_range(3, 1));
    end
    cnt_clr = 1'b0;
    idle(3);

    // Reset with two words in flight: one in stage 1, one on the input.
    send_rand(1);
    cin  = encode(7'h2A);
    cvld = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("midreset_outputs", {dvld, cerr, uerr, dout, syn}, '0);
    chk("midreset_counters", {ccnt, ucnt}, '0);
    sb.delete();
    @(posedge clk); #1;
    rst  = 1'b1;
    cvld = 1'b0;
    idle(4);
    send_rand(1);
    idle(3);

    // Back-to-back single-error stream, then a clear alongside an error word.
    for (int i = 0; i < STREAM; i++) send_rand(1);
    chk("ccnt_saturated", 32'(ccnt), CNT_ON ? 32'h0000FFFF : 32'd0);
    cnt_clr = 1'b1;
    send_rand(1);
    cnt_clr = 1'b0;
    chk("ccnt_cleared", 32'(ccnt), 32'd0);
    idle(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hd_top.md
HD_TOP -- requirements
Module: hd_top

Interface
REQ-001 Parameter k, default 7: data width in bits.
REQ-002 Parameter m, default 4: parity width in bits; n = k+m is the codeword width.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-low.
REQ-005 cin  input  n: received Hamming codeword.
REQ-006 cvld  input  1: cin is valid this cycle.
REQ-007 cnt_clr  input  1: synchronous clear of the error counters.
REQ-008 dout  output  k: decoded, corrected data.
REQ-009 dvld  output  1: dout and the status outputs are valid this cycle.
REQ-010 syn  output  m: syndrome of the word presented on dout.
REQ-011 cerr  output  1: a single-bit error was corrected.
REQ-012 uerr  output  1: the syndrome is invalid (greater than n) and the word is uncorrectable.
REQ-013 ccnt  output  16: count of corrected words.
REQ-014 ucnt  output  16: count of uncorrectable words.

Function
REQ-015 Codeword bit cin[j] SHALL be Hamming position j+1.
REQ-016 Parity bits SHALL sit at positions 1, 2, 4, 8, ... (powers of two), and parity SHALL be even.
REQ-017 Data bit d[0..k-1] SHALL occupy the non-power-of-two positions in ascending order; for k=7 these are positions 3, 5, 6, 7, 9, 10, 11.
REQ-018 Syndrome bit i SHALL be the XOR of every cin bit whose position has bit i set.
REQ-019 Pipeline stage 1 SHALL register the codeword, the syndrome and the valid bit.
REQ-020 Pipeline stage 2 SHALL correct the word, extract the data and register all outputs.
REQ-021 Latency SHALL be 2 cycles: cvld at edge t gives dvld at edge t+2.
REQ-022 The block SHALL accept one word per cycle with no stall; back-to-back words and gaps of any length SHALL both be handled.
REQ-023 syn==0: dout = extracted data; cerr=0; uerr=0.
REQ-024 1<=syn<=n: the bit at position syn SHALL be inverted before extraction; cerr=1; uerr=0.
REQ-025 A correction at a parity position SHALL set cerr but leave dout unchanged.
REQ-026 syn>n: dout = uncorrected extraction; cerr=0; uerr=1.
REQ-027 When dvld=0, dout, syn, cerr and uerr SHALL hold their previous values.
REQ-028 cerr and uerr SHALL never be 1 in the same cycle.
REQ-029 ccnt SHALL increment by 1 on every cycle with dvld=1 and cerr=1.
REQ-030 ucnt SHALL increment by 1 on every cycle with dvld=1 and uerr=1.
REQ-031 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-032 cnt_clr=1 SHALL zero both counters on the next edge; if an increment falls in the same cycle, the clear SHALL win.

Reset
REQ-033 rst=0 SHALL immediately force dout=0, dvld=0, syn=0, cerr=0, uerr=0, ccnt=0, ucnt=0, and clear all pipeline valid bits.
REQ-034 Words in flight when reset asserts SHALL be discarded and never emerge with dvld=1.
REQ-035 The first word accepted after reset deasserts SHALL appear 2 cycles after its cvld.

Configuration
REQ-036 The macro HD_ERR_CNT_EN SHALL control the error counters.
REQ-037 With HD_ERR_CNT_EN defined, the counters and cnt_clr SHALL behave per REQ-029 to REQ-032.
REQ-038 Without HD_ERR_CNT_EN, ccnt and ucnt SHALL be tied to 0, cnt_clr SHALL be ignored, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-039 Clean word: cin=11'h484, cvld for 1 cycle -> 2 cycles later dvld=1, dout=7'h41, syn=0, cerr=0, uerr=0.
REQ-040 Data-bit error: cin=11'h494 (position 5 flipped) -> dout=7'h41, syn=5, cerr=1, ccnt=1.
REQ-041 Double parity error: cin=11'h40C (positions 4 and 8 flipped) -> syn=12, uerr=1, cerr=0, dout=7'h41, ucnt=1.
REQ-042 Streaming and counters: 70000 consecutive words, each with a single error -> dvld high every cycle, correct data throughout, ccnt saturates at 16'hFFFF; then cnt_clr together with an error word -> ccnt=0.
REQ-043 Mid-stream reset: rst low for 1 cycle while 2 words are in flight -> outputs zero immediately and no dvld pulse for the flushed words.
REQ-044 Build without HD_ERR_CNT_EN and rerun REQ-040 -> same dout and cerr, ccnt=0.
